jtpopeye_objdma: RTL and testbench

- Parametrised object-table DMA engine. Successor to the fixed Popeye sprite DMA.
- On each vertical blank it takes the main CPU bus with a BUSRQ/BUSAK handshake. It then copies ENTRIES records of BYTES bytes each from main RAM into the object buffer write port, and releases the bus.
- Sits between the main memory DMA port and the object buffer in the video subsystem.
- Generalises the original engine in entry count, entry width, base address and abort handling.

---
 rtl/jtpopeye_objdma.sv | 196 +++++++++++++++++++
 tb/tb_jtpopeye_objdma.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_objdma.sv
// jtpopeye_objdma: object-table DMA engine.
//
// On each rising edge of VB the engine requests the main CPU bus. Once the bus
// is acknowledged, it copies ENTRIES records of BYTES bytes each from main RAM
// (starting at BASE, wrapping modulo 2^AW) into the object buffer write port.
// It then releases the bus.
//
// Optional build macro: JTPOPEYE_OBJDMA_DBLBUF_EN
//   defined   - obj_bank toggles after every complete frame; writes target ~obj_bank
//   undefined - obj_bank is tied to 0 (single buffer)
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cen              byte-rate clock enable
//   VB               vertical blank
//   busrq_n/busak_n  CPU bus request / acknowledge (active low)
//   AD_DMA, dma_cs   source byte address and read strobe
//   DD_DMA           read data, valid one cen after the address
//   obj_we/addr/data object buffer write port (one-clk strobe, byte 0 in LSBs)
//   obj_bank         buffer bank selector
//   done             one-clk pulse at the end of a transfer
//   incomplete       last transfer was cut short
`timescale 1ns/1ps

module jtpopeye_objdma #(
    parameter int unsigned AW      = 10,
    parameter int unsigned BASE    = 0,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned BYTES   = 4,
    parameter int unsigned OAW     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              VB,
    output logic              busrq_n,
    input  logic              busak_n,
    output logic [AW-1:0]     AD_DMA,
    output logic              dma_cs,
    input  logic [7:0]        DD_DMA,
    output logic              obj_we,
    output logic [OAW-1:0]    obj_addr,
    output logic [8*BYTES-1:0] obj_data,
    output logic              obj_bank,
    output logic              done,
    output logic              incomplete
);

    localparam int unsigned DW = 8 * BYTES;
    localparam int unsigned RW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAddr,
        StData,
        StNext,
        StRel
    } state_e;

    state_e        state;
    logic          vb_q;
    logic          cs_q;
    logic          abort_q;
    logic [RW-1:0] rec_q;
    logic [1:0]    byte_q;
    logic          vb_fall;
    logic          byte_more;
    logic          rec_last;

    function automatic logic [AW-1:0] src_addr(input logic [RW-1:0] r, input logic [1:0] b);
        return AW'(BASE + 32'(r) * BYTES + 32'(b));
    endfunction

    assign vb_fall   = vb_q & ~VB;
    assign byte_more = 32'(byte_q) < (BYTES - 1);
    assign rec_last  = 32'(rec_q) == (ENTRIES - 1);

    // The strobe is gated by the acknowledge so it drops immediately when the
    // CPU takes the bus back. The FSM freezes in the same cycle.
    assign dma_cs = cs_q & ~busak_n;

`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
    logic bank_q;
    assign obj_bank = bank_q;
`else
    assign obj_bank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            vb_q       <= 1'b0;
            cs_q       <= 1'b0;
            abort_q    <= 1'b0;
            rec_q      <= '0;
            byte_q     <= '0;
            busrq_n    <= 1'b1;
            AD_DMA     <= AW'(BASE);
            obj_we     <= 1'b0;
            obj_addr   <= '0;
            obj_data   <= '0;
            done       <= 1'b0;
            incomplete <= 1'b0;
`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
            bank_q     <= 1'b0;
`endif
        end else begin
            // Strobes last exactly one clk even when cen is high for longer.
            obj_we <= 1'b0;
            done   <= 1'b0;
            if (cen) begin
                vb_q <= VB;
                case (state)
                    StIdle: begin
                        if (VB && !vb_q) begin
                            busrq_n    <= 1'b0;
                            incomplete <= 1'b0;
                            state      <= StReq;
                        end
                    end
                    StReq: begin
                        if (!VB) begin
                            // Blanking ended before the CPU let go of the bus.
                            busrq_n    <= 1'b1;
                            incomplete <= 1'b1;
                            done       <= 1'b1;
                            state      <= StIdle;
                        end else if (!busak_n) begin
                            cs_q   <= 1'b1;
                            AD_DMA <= src_addr(rec_q, byte_q);
                            state  <= StAddr;
                        end
                    end
                    StAddr: begin
                        if (vb_fall) abort_q <= 1'b1;
                        if (!busak_n) begin
                            cs_q  <= 1'b0;
                            state <= StData;
                        end
                    end
                    StData: begin
                        if (vb_fall) abort_q <= 1'b1;
                        if (!busak_n) begin
                            for (int unsigned i = 0; i < BYTES; i++) begin
                                if (byte_q == 2'(i)) obj_data[8*i +: 8] <= DD_DMA;
                            end
                            if (byte_more) begin
                                byte_q <= byte_q + 2'd1;
                                AD_DMA <= src_addr(rec_q, byte_q + 2'd1);
                                cs_q   <= 1'b1;
                                state  <= StAddr;
                            end else begin
                                obj_we   <= 1'b1;
                                obj_addr <= OAW'(rec_q);
                                state    <= StNext;
                            end
                        end
                    end
                    StNext: begin
                        if (rec_last || abort_q || vb_fall) begin
                            incomplete <= abort_q | vb_fall;
                            state      <= StRel;
                        end else begin
                            rec_q  <= rec_q + RW'(1);
                            byte_q <= '0;
                            AD_DMA <= src_addr(rec_q + RW'(1), 2'd0);
                            cs_q   <= 1'b1;
                            state  <= StAddr;
                        end
                    end
                    StRel: begin
                        busrq_n <= 1'b1;
                        cs_q    <= 1'b0;
                        done    <= 1'b1;
                        rec_q   <= '0;
                        byte_q  <= '0;
                        abort_q <= 1'b0;
                        AD_DMA  <= AW'(BASE);
`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
                        // Only a fully written bank is handed to the display.
                        if (!incomplete) bank_q <= ~bank_q;
`endif
                        state   <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    // DW is the record width; keep it visible for readers of the port list.
    logic [DW-1:0] unused_dw;
    assign unused_dw = obj_data;

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Directed testbench for jtpopeye_objdma.
// Instance a: ENTRIES=4, BYTES=3, BASE=0x100, and a bus-steal override.
// Instance b: ENTRIES=2, BYTES=4, BASE=0x3FE, to exercise address wrap.
// The RAM model returns the low address byte.
`timescale 1ns/1ps

module tb_jtpopeye_objdma;

`ifdef JTPOPEYE_OBJDMA_DBLBUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, cen, VB, steal;
    always #5 clk = ~clk;

    // instance a
    logic        busrq_n, busak_n, dma_cs, obj_we, obj_bank, done, incomplete;
    logic [9:0]  AD_DMA;
    logic [7:0]  DD_DMA;
    logic [1:0]  obj_addr;
    logic [23:0] obj_data;
    logic        pend, grant;

    // instance b
    logic        busrq_n_b, busak_n_b, dma_cs_b, obj_we_b, obj_bank_b, done_b, incomplete_b;
    logic [9:0]  AD_DMA_b;
    logic [7:0]  DD_DMA_b;
    logic [0:0]  obj_addr_b;
    logic [31:0] obj_data_b;
    logic        pend_b, grant_b;

    jtpopeye_objdma #(.AW(10), .BASE(32'h100), .ENTRIES(4), .BYTES(3), .OAW(2)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB),
        .busrq_n(busrq_n), .busak_n(busak_n), .AD_DMA(AD_DMA), .dma_cs(dma_cs),
        .DD_DMA(DD_DMA), .obj_we(obj_we), .obj_addr(obj_addr), .obj_data(obj_data),
        .obj_bank(obj_bank), .done(done), .incomplete(incomplete)
    );

    jtpopeye_objdma #(.AW(10), .BASE(32'h3FE), .ENTRIES(2), .BYTES(4), .OAW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB),
        .busrq_n(busrq_n_b), .busak_n(busak_n_b), .AD_DMA(AD_DMA_b), .dma_cs(dma_cs_b),
        .DD_DMA(DD_DMA_b), .obj_we(obj_we_b), .obj_addr(obj_addr_b), .obj_data(obj_data_b),
        .obj_bank(obj_bank_b), .done(done_b), .incomplete(incomplete_b)
    );

    // CPU grants the bus 2 cens after the request; 'steal' takes it back.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0; grant <= 1'b0; pend_b <= 1'b0; grant_b <= 1'b0;
        end else begin
            if (busrq_n) begin pend <= 1'b0; grant <= 1'b0; end
            else if (cen) begin pend <= 1'b1; grant <= pend; end
            if (busrq_n_b) begin pend_b <= 1'b0; grant_b <= 1'b0; end
            else if (cen) begin pend_b <= 1'b1; grant_b <= pend_b; end
        end
    end
    assign busak_n   = ~grant | steal;
    assign busak_n_b = ~grant_b;

    // RAM: byte at address a is a[7:0], registered one cen after the strobe.
    always @(posedge clk) begin
        if (cen && dma_cs)   DD_DMA   <= AD_DMA[7:0];
        if (cen && dma_cs_b) DD_DMA_b <= AD_DMA_b[7:0];
    end

    logic [25:0] wq[$];
    logic [32:0] wq_b[$];
    logic [9:0]  rq_b[$];
    logic        dq[$];
    logic        dq_b[$];

    always @(negedge clk) begin
        if (obj_we)   wq.push_back({obj_addr, obj_data});
        if (obj_we_b) wq_b.push_back({obj_addr_b, obj_data_b});
        if (dma_cs_b) rq_b.push_back(AD_DMA_b);
        if (done)     dq.push_back(1'b1);
        if (done_b)   dq_b.push_back(1'b1);
    end

    int vecs = 0;
    int errs = 0;
    logic exp_bank = 1'b0;
    logic [23:0] exp_rec [4] = '{24'h020100, 24'h050403, 24'h080706, 24'h0B0A09};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wq.delete(); wq_b.delete(); rq_b.delete(); dq.delete(); dq_b.delete();
    endtask

    task automatic wait_ack();
        int n = 0;
        while (busak_n !== 1'b0 && n < 20) begin tick(); n++; end
        vecs++;
        if (busak_n !== 1'b0) begin
            errs++;
            $display("FAIL ack_wait: busak_n=%b after %0d cycles, required 0", busak_n, n);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (dq.size() == 0 && n < budget) begin tick(); n++; end
        vecs++;
        if (dq.size() == 0) begin
            errs++;
            $display("FAIL done_wait: no done pulse within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cen = 1'b1; VB = 1'b0; steal = 1'b0;
        #12;
        vecs++;
        if ({busrq_n, dma_cs, AD_DMA, obj_we, obj_addr, obj_data, obj_bank, done, incomplete}
            !== {1'b1, 1'b0, 10'h100, 1'b0, 2'd0, 24'd0, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_state: busrq_n=%b cs=%b ad=%h we=%b oa=%0d od=%h bank=%b done=%b inc=%b",
                     busrq_n, dma_cs, AD_DMA, obj_we, obj_addr, obj_data, obj_bank, done,
                     incomplete);
        end
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_cen_gate();
        cen = 1'b0; VB = 1'b1;
        repeat (4) tick();
        vecs++;
        if (busrq_n !== 1'b1) begin
            errs++;
            $display("FAIL cen_gate: busrq_n=%b with cen low, required 1", busrq_n);
        end
        VB = 1'b0; cen = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_full_frame();
        int c = 0;
        clear_logs();
        VB = 1'b1;
        wait_ack();
        while (busrq_n !== 1'b1 && c < 100) begin tick(); c++; end
        vecs++;
        if (c != 30) begin
            errs++;
            $display("FAIL frame_latency: busrq_n released after %0d cens, required 30", c);
        end
        repeat (2) tick();
        if (DBL) exp_bank = ~exp_bank;
        vecs++;
        if (dq.size() != 1) begin
            errs++; $display("FAIL full_done: %0d done pulses, required 1", dq.size());
        end
        vecs++;
        if (wq.size() != 4) begin
            errs++; $display("FAIL full_count: %0d writes, required 4", wq.size());
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (i >= wq.size() || wq[i] !== {2'(i), exp_rec[i]}) begin
                errs++;
                $display("FAIL full_rec%0d: got %h, required %h", i,
                         (i < wq.size()) ? wq[i] : 26'h0, {2'(i), exp_rec[i]});
            end
        end
        vecs++;
        if (incomplete !== 1'b0 || obj_bank !== exp_bank) begin
            errs++;
            $display("FAIL full_status: inc=%b bank=%b, required inc=0 bank=%b",
                     incomplete, obj_bank, exp_bank);
        end
        VB = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_wrap();
        int n = 0;
        logic [9:0] exp_ad [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        clear_logs();
        VB = 1'b1;
        while ((dq.size() == 0 || dq_b.size() == 0) && n < 100) begin tick(); n++; end
        repeat (2) tick();
        if (DBL) exp_bank = ~exp_bank;
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (i >= rq_b.size() || rq_b[i] !== exp_ad[i]) begin
                errs++;
                $display("FAIL wrap_addr%0d: got %h, required %h", i,
                         (i < rq_b.size()) ? rq_b[i] : 10'h0, exp_ad[i]);
            end
        end
        vecs++;
        if (wq_b.size() != 2 || wq_b[0] !== {1'b0, 32'h0100FFFE}
            || wq_b[1] !== {1'b1, 32'h05040302}) begin
            errs++;
            $display("FAIL wrap_data: %0d writes, first %h, required 2 writes 0_0100fffe 1_05040302",
                     wq_b.size(), (wq_b.size() > 0) ? wq_b[0] : 33'h0);
        end
        vecs++;
        if (obj_bank !== exp_bank) begin
            errs++; $display("FAIL bank_second: bank=%b, required %b", obj_bank, exp_bank);
        end
        VB = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_abort();
        clear_logs();
        VB = 1'b1;
        wait_ack();
        repeat (17) tick();  // now in ADDR of record 2, byte 1
        VB = 1'b0;
        wait_done(40);
        repeat (2) tick();
        vecs++;
        if (wq.size() != 3) begin
            errs++; $display("FAIL abort_count: %0d writes, required 3", wq.size());
        end
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (i >= wq.size() || wq[i] !== {2'(i), exp_rec[i]}) begin
                errs++;
                $display("FAIL abort_rec%0d: got %h, required %h", i,
                         (i < wq.size()) ? wq[i] : 26'h0, {2'(i), exp_rec[i]});
            end
        end
        vecs++;
        if (incomplete !== 1'b1 || dq.size() != 1 || obj_bank !== exp_bank) begin
            errs++;
            $display("FAIL abort_status: inc=%b done=%0d bank=%b, required inc=1 done=1 bank=%b",
                     incomplete, dq.size(), obj_bank, exp_bank);
        end
        repeat (3) tick();
    endtask

    task automatic test_req_abort();
        clear_logs();
        steal = 1'b1;
        VB = 1'b1;
        repeat (4) tick();
        vecs++;
        if (busrq_n !== 1'b0) begin
            errs++; $display("FAIL req_pending: busrq_n=%b, required 0", busrq_n);
        end
        VB = 1'b0;
        wait_done(10);
        tick();
        vecs++;
        if (busrq_n !== 1'b1 || incomplete !== 1'b1 || wq.size() != 0 || dq.size() != 1) begin
            errs++;
            $display("FAIL req_abort: busrq_n=%b inc=%b writes=%0d done=%0d, required 1 1 0 1",
                     busrq_n, incomplete, wq.size(), dq.size());
        end
        steal = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_bus_loss();
        clear_logs();
        VB = 1'b1;
        wait_ack();
        tick();
        vecs++;
        if (incomplete !== 1'b0) begin
            errs++; $display("FAIL inc_clear: incomplete=%b at start, required 0", incomplete);
        end
        repeat (9) tick();  // ADDR of record 1, byte 1
        vecs++;
        if (AD_DMA !== 10'h104 || dma_cs !== 1'b1) begin
            errs++;
            $display("FAIL loss_pre: ad=%h cs=%b, required 104 1", AD_DMA, dma_cs);
        end
        steal = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++;
            if (AD_DMA !== 10'h104 || dma_cs !== 1'b0 || busrq_n !== 1'b0) begin
                errs++;
                $display("FAIL loss_hold%0d: ad=%h cs=%b busrq_n=%b, required 104 0 0",
                         i, AD_DMA, dma_cs, busrq_n);
            end
        end
        steal = 1'b0;
        wait_done(60);
        repeat (2) tick();
        if (DBL) exp_bank = ~exp_bank;
        vecs++;
        if (wq.size() != 4) begin
            errs++; $display("FAIL loss_count: %0d writes, required 4", wq.size());
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (i >= wq.size() || wq[i] !== {2'(i), exp_rec[i]}) begin
                errs++;
                $display("FAIL loss_rec%0d: got %h, required %h", i,
                         (i < wq.size()) ? wq[i] : 26'h0, {2'(i), exp_rec[i]});
            end
        end
        vecs++;
        if (incomplete !== 1'b0 || obj_bank !== exp_bank) begin
            errs++;
            $display("FAIL loss_status: inc=%b bank=%b, required 0 %b",
                     incomplete, obj_bank, exp_bank);
        end
        VB = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        clear_logs();
        VB = 1'b1;
        wait_ack();
        repeat (5) tick();  // record 0 partially assembled
        #2;
        rst_n = 1'b0;
        #1;
        exp_bank = 1'b0;
        vecs++;
        if ({busrq_n, dma_cs, AD_DMA, obj_we, obj_addr, obj_data, obj_bank, done, incomplete}
            !== {1'b1, 1'b0, 10'h100, 1'b0, 2'd0, 24'd0, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_mid: busrq_n=%b cs=%b ad=%h od=%h bank=%b inc=%b",
                     busrq_n, dma_cs, AD_DMA, obj_data, obj_bank, incomplete);
        end
        VB = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        clear_logs();
        VB = 1'b1;
        wait_done(60);
        repeat (2) tick();
        if (DBL) exp_bank = ~exp_bank;
        vecs++;
        if (wq.size() != 4 || wq[0] !== {2'd0, 24'h020100} || wq[3] !== {2'd3, 24'h0B0A09}) begin
            errs++;
            $display("FAIL restart: %0d writes, first %h, required 4 writes from 0_020100",
                     wq.size(), (wq.size() > 0) ? wq[0] : 26'h0);
        end
        vecs++;
        if (obj_bank !== exp_bank) begin
            errs++; $display("FAIL restart_bank: bank=%b, required %b", obj_bank, exp_bank);
        end
        VB = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_cen_gate();
        test_full_frame();
        test_wrap();
        test_abort();
        test_req_abort();
        test_bus_loss();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
